// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: button/enable inputs and strobe/mode/blank outputs of the clock-setting controller.
// Signals:
//   i_run_en     timekeeping enable (0 freezes the prescaler in RUN)
//   i_btn_mode   raw asynchronous mode button, active-high
//   i_btn_up     raw asynchronous increment button, active-high
//   o_tick_1s    one-cycle seconds-advance strobe
//   o_inc_hr/min/sec  one-cycle field-increment strobes
//   o_mode       00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC
//   o_blank_hr/min/sec  blank request for the blinking field
// Modports: master drives the inputs (stimulus side), slave is the controller.
interface clock_set_ctrl_if;
    logic       i_run_en;
    logic       i_btn_mode;
    logic       i_btn_up;
    logic       o_tick_1s;
    logic       o_inc_hr;
    logic       o_inc_min;
    logic       o_inc_sec;
    logic [1:0] o_mode;
    logic       o_blank_hr;
    logic       o_blank_min;
    logic       o_blank_sec;
    modport master (
        output i_run_en, i_btn_mode, i_btn_up,
        input  o_tick_1s, o_inc_hr, o_inc_min, o_inc_sec, o_mode,
        input  o_blank_hr, o_blank_min, o_blank_sec
    );
    modport slave (
        input  i_run_en, i_btn_mode, i_btn_up,
        output o_tick_1s, o_inc_hr, o_inc_min, o_inc_sec, o_mode,
        output o_blank_hr, o_blank_min, o_blank_sec
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven RUN/SET_HR/SET_MIN/SET_SEC controller with 1 s prescaler,
// debounced buttons, auto-repeat, idle timeout and field blinking.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    clock_set_ctrl_if.slave (run_en, buttons in; tick, inc strobes, mode, blanks out)
module clock_set_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int TIMEOUT_CYCLES  = 500000000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic             clk,
    input  logic             reset,
    clock_set_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10, SET_SEC = 2'b11} state_t;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int PW   = $clog2(CLK_HZ + 1);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW   = $clog2(RMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW   = $clog2(BLINK_CYCLES + 1);
    localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_MAX   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_MAX   = RW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0] IDLE_MAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_nx;
    logic [1:0]    r_sync0;
    logic [1:0]    r_sync1;
    logic [1:0]    r_deb;
    logic [1:0]    r_deb_q;
    logic [DW-1:0] r_db_cnt [2];
    logic [PW-1:0] r_pre;
    logic [RW-1:0] r_rep;
    logic          r_rep_act;
    logic          r_rep_first;
    logic [TW-1:0] r_idle;
    logic [BW-1:0] r_blink;
    logic          r_phase;
    logic          r_inc_hr;
    logic          r_inc_min;
    logic          r_inc_sec;
    logic          w_mode_press;
    logic          w_up_press;
    logic          w_set;
    logic          w_run;
    logic          w_timeout;
    logic          w_rep_fire;
    logic          w_inc;
    logic          w_chg;

    // Button pipelines, bit 0 = mode, bit 1 = up: 2-flop synchronizer, then a
    // debouncer that adopts the synchronized level after DEBOUNCE_CYCLES differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync0 <= {bus.i_btn_up, bus.i_btn_mode};
            r_sync1 <= r_sync0;
            r_deb_q <= r_deb;
            for (int i = 0; i < 2; i++) begin
                if (r_sync1[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_MAX) begin
                    r_db_cnt[i] <= '0;
                    r_deb[i]    <= r_sync1[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign w_mode_press = r_deb[0] & ~r_deb_q[0];
    assign w_up_press   = r_deb[1] & ~r_deb_q[1];
    assign w_set        = r_state != RUN;
    assign w_run        = ~w_set & bus.i_run_en;
    // A press in the same cycle restarts the idle window, so it also vetoes the timeout.
    assign w_timeout    = w_set & (r_idle == IDLE_MAX) & ~w_mode_press & ~w_up_press;
    assign w_rep_fire   = r_rep_act & r_deb[1] & (r_rep == (r_rep_first ? DLY_MAX : PER_MAX));
    // Mode press and timeout both change state and take priority over any increment.
    assign w_inc        = w_set & ~w_mode_press & ~w_timeout & (w_up_press | w_rep_fire);
    assign w_chg        = w_state_nx != r_state;

    always_comb begin
        w_state_nx = r_state;
        if (w_mode_press) w_state_nx = state_t'(r_state + 2'd1);
        else if (w_timeout) w_state_nx = RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RUN;
        else r_state <= w_state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre       <= '0;
            r_idle      <= '0;
            r_rep       <= '0;
            r_rep_act   <= 1'b0;
            r_rep_first <= 1'b0;
            r_blink     <= '0;
            r_phase     <= 1'b0;
            r_inc_hr    <= 1'b0;
            r_inc_min   <= 1'b0;
            r_inc_sec   <= 1'b0;
        end else begin
            // Entering or staying in a SET state parks the prescaler at 0 so the
            // first tick after returning to RUN is a full second away.
            r_pre     <= (w_state_nx != RUN) ? '0 : !w_run ? r_pre : (r_pre == PRE_MAX) ? '0 : r_pre + PW'(1);
            r_idle    <= (~w_set | w_mode_press | w_up_press | w_timeout) ? '0 : r_idle + TW'(1);
            r_inc_hr  <= w_inc & (r_state == SET_HR);
            r_inc_min <= w_inc & (r_state == SET_MIN);
            r_inc_sec <= w_inc & (r_state == SET_SEC);
            // Repetition arms only on the initial pulse of a fresh press.
            if (w_inc & w_up_press) begin
                r_rep_act   <= 1'b1;
                r_rep_first <= 1'b1;
                r_rep       <= '0;
            end else if (~r_rep_act | ~r_deb[1] | w_chg) begin
                r_rep_act <= 1'b0;
                r_rep     <= '0;
            end else if (w_rep_fire) begin
                r_rep       <= '0;
                r_rep_first <= 1'b0;
            end else begin
                r_rep <= r_rep + RW'(1);
            end
            // Restarting the blink on any change keeps the just-adjusted field visible.
            if (~w_set | w_chg | w_inc) begin
                r_blink <= '0;
                r_phase <= 1'b0;
            end else if (r_blink == BLINK_MAX) begin
                r_blink <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_blink <= r_blink + BW'(1);
            end
        end
    end

    assign bus.o_tick_1s   = w_run & (r_pre == PRE_MAX);
    assign bus.o_inc_hr    = r_inc_hr;
    assign bus.o_inc_min   = r_inc_min;
    assign bus.o_inc_sec   = r_inc_sec;
    assign bus.o_mode      = r_state;
    assign bus.o_blank_hr  = r_phase & (r_state == SET_HR);
    assign bus.o_blank_min = r_phase & (r_state == SET_MIN);
    assign bus.o_blank_sec = r_phase & (r_state == SET_SEC);
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed, table-driven bench for clock_set_ctrl with small parameters.
// Sampling point: #1 after each rising edge; "k steps" means k rising edges after a sample.
module tb_clock_set_ctrl;
    logic clk;
    logic reset;
    clock_set_ctrl_if bus();

    clock_set_ctrl #(
        .CLK_HZ(10), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20),
        .REPEAT_PERIOD(5), .TIMEOUT_CYCLES(100), .BLINK_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int m, u, en, n;
        int mode, hr, mn, sc;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_tick, n_hr, n_min, n_sec;
    int n_multi = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr();
        n_tick = 0; n_hr = 0; n_min = 0; n_sec = 0;
    endtask

    task automatic step();
        int s;
        @(posedge clk);
        #1;
        cyc++;
        s = int'(bus.o_tick_1s) + int'(bus.o_inc_hr) + int'(bus.o_inc_min) + int'(bus.o_inc_sec);
        if (s > 1) n_multi++;
        n_tick += int'(bus.o_tick_1s);
        n_hr   += int'(bus.o_inc_hr);
        n_min  += int'(bus.o_inc_min);
        n_sec  += int'(bus.o_inc_sec);
    endtask

    task automatic wait_mode(input int m, input int budget);
        int n;
        n = 0;
        while (int'(bus.o_mode) != m && n < budget) begin
            step();
            n++;
        end
        chk("wait_mode", int'(bus.o_mode), m);
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.o_tick_1s && n < budget);
    endtask

    task automatic wait_hr(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.o_inc_hr && n < budget);
    endtask

    task automatic press_mode();
        bus.i_btn_mode = 1'b1;
        repeat (10) step();
        bus.i_btn_mode = 1'b0;
        repeat (12) step();
    endtask

    task automatic do_reset();
        bus.i_btn_mode = 1'b0;
        bus.i_btn_up   = 1'b0;
        bus.i_run_en   = 1'b1;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    vec_t tbl [18];
    int tq[$];
    int iq[$];
    int n, t0, t1, other;

    initial begin
        // Each record holds its inputs for n steps; mode is checked at the end
        // and increment strobes are counted over the record.
        tbl = '{
            '{0, 1, 1, 12, 0, 0, 0, 0},  // up press in RUN is ignored
            '{0, 0, 1, 12, 0, 0, 0, 0},
            '{1, 0, 1,  2, 0, 0, 0, 0},  // 2-cycle mode glitch
            '{0, 0, 1, 10, 0, 0, 0, 0},
            '{1, 0, 1, 10, 1, 0, 0, 0},  // RUN -> SET_HR
            '{0, 0, 1, 12, 1, 0, 0, 0},
            '{0, 1, 1, 10, 1, 1, 0, 0},  // one inc_hr
            '{0, 0, 1, 12, 1, 0, 0, 0},
            '{1, 1, 1, 10, 2, 0, 0, 0},  // simultaneous press: mode wins
            '{0, 0, 1, 12, 2, 0, 0, 0},
            '{0, 1, 0, 10, 2, 0, 1, 0},  // inc_min, run_en irrelevant in SET
            '{0, 0, 1, 12, 2, 0, 0, 0},
            '{1, 0, 1, 10, 3, 0, 0, 0},  // SET_MIN -> SET_SEC
            '{0, 0, 1, 12, 3, 0, 0, 0},
            '{0, 1, 1, 10, 3, 0, 0, 1},  // inc_sec
            '{0, 0, 1, 12, 3, 0, 0, 0},
            '{1, 0, 1, 10, 0, 0, 0, 0},  // SET_SEC -> RUN
            '{0, 0, 1, 12, 0, 0, 0, 0}
        };
        bus.i_btn_mode = 1'b0;
        bus.i_btn_up   = 1'b0;
        bus.i_run_en   = 1'b0;
        reset = 1'b1;
        clr();
        repeat (3) step();
        chk("rst_mode", int'(bus.o_mode), 0);
        chk("rst_strobes", int'(bus.o_tick_1s) + int'(bus.o_inc_hr) + int'(bus.o_inc_min) + int'(bus.o_inc_sec), 0);
        chk("rst_blanks", int'(bus.o_blank_hr) + int'(bus.o_blank_min) + int'(bus.o_blank_sec), 0);

        // Tick cadence: release is sample 0 (cycle 1), ticks land on the 10th, 20th, 30th cycles.
        bus.i_run_en = 1'b1;
        reset = 1'b0;
        chk("tick_at_release", int'(bus.o_tick_1s), 0);
        for (int k = 1; k < 35; k++) begin
            step();
            if (bus.o_tick_1s) tq.push_back(k);
        end
        chk("tick_count", tq.size(), 3);
        for (int i = 0; i < 3; i++) chk("tick_at", (i < tq.size()) ? tq[i] : -1, 9 + 10 * i);
        // Prescaler sits at 4 now; freeze it, then it needs 5 more edges to reach 9.
        bus.i_run_en = 1'b0;
        clr();
        repeat (10) step();
        chk("tick_frozen", n_tick, 0);
        bus.i_run_en = 1'b1;
        wait_tick(20, n);
        chk("tick_resume", n, 5);

        for (int i = 0; i < 18; i++) begin
            bus.i_btn_mode = 1'(tbl[i].m);
            bus.i_btn_up   = 1'(tbl[i].u);
            bus.i_run_en   = 1'(tbl[i].en);
            clr();
            repeat (tbl[i].n) step();
            chk($sformatf("vec%0d_mode", i), int'(bus.o_mode), tbl[i].mode);
            chk($sformatf("vec%0d_hr", i), n_hr, tbl[i].hr);
            chk($sformatf("vec%0d_min", i), n_min, tbl[i].mn);
            chk($sformatf("vec%0d_sec", i), n_sec, tbl[i].sc);
        end

        // Blink in SET_HR: phase flips every 8 cycles from entry; an inc restarts it.
        do_reset();
        bus.i_btn_mode = 1'b1;
        wait_mode(1, 20);
        bus.i_btn_mode = 1'b0;
        other = 0;
        clr();
        for (int m = 0; m < 24; m++) begin
            if (m > 0) step();
            chk("blink_hr", int'(bus.o_blank_hr), (m / 8) % 2);
            other += int'(bus.o_blank_min) + int'(bus.o_blank_sec);
        end
        chk("blink_others", other, 0);
        chk("blink_no_tick", n_tick, 0);
        bus.i_btn_up = 1'b1;
        wait_hr(20, n);
        bus.i_btn_up = 1'b0;
        chk("blink_inc_lat", n, 7);
        chk("blink_clr_at_inc", int'(bus.o_blank_hr), 0);
        repeat (7) step();
        chk("blink_clr_p7", int'(bus.o_blank_hr), 0);
        step();
        chk("blink_clr_p8", int'(bus.o_blank_hr), 1);

        // Auto-repeat in SET_MIN: initial pulse, then +20, +25, +30, +35.
        do_reset();
        press_mode();
        press_mode();
        chk("rep_mode", int'(bus.o_mode), 2);
        clr();
        bus.i_btn_up = 1'b1;
        for (int i = 1; i <= 52; i++) begin
            if (i == 41) bus.i_btn_up = 1'b0;
            step();
            if (bus.o_inc_min) iq.push_back(i);
        end
        chk("rep_count", iq.size(), 5);
        for (int i = 0; i < 5; i++) chk("rep_offset", (i < iq.size()) ? iq[i] - iq[0] : -1, (i == 0) ? 0 : 15 + 5 * i);
        chk("rep_first_lat", (iq.size() > 0) ? iq[0] : -1, 7);
        chk("rep_other", n_hr + n_sec + n_tick, 0);

        // Timeout: SET_SEC is held for 100 samples, then RUN; first tick in the 10th RUN cycle.
        do_reset();
        press_mode();
        press_mode();
        bus.i_btn_mode = 1'b1;
        wait_mode(3, 20);
        bus.i_btn_mode = 1'b0;
        t0 = cyc;
        clr();
        wait_mode(0, 200);
        chk("timeout_len", cyc - t0, 100);
        chk("timeout_no_tick", n_tick, 0);
        t1 = cyc;
        wait_tick(30, n);
        chk("timeout_first_tick", n, 9);

        // Reset in the middle of auto-repeat, asserted while a repeat pulse is high.
        do_reset();
        press_mode();
        bus.i_btn_up = 1'b1;
        wait_hr(20, n);
        chk("rst_rep_init", n, 7);
        wait_hr(30, n);
        chk("rst_rep_first", n, 20);
        reset = 1'b1;
        #1;
        chk("rst_async_inc", int'(bus.o_inc_hr), 0);
        chk("rst_async_mode", int'(bus.o_mode), 0);
        chk("rst_async_blank", int'(bus.o_blank_hr), 0);
        repeat (3) step();
        reset = 1'b0;
        clr();
        repeat (40) step();
        chk("rst_held_up", n_hr + n_min + n_sec, 0);
        chk("rst_held_mode", int'(bus.o_mode), 0);
        bus.i_btn_up = 1'b0;

        chk("onehot_strobes", n_multi, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clk cycles per 1 s tick.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable samples required to accept a button level.
REQ-003 Parameter REPEAT_DELAY, default 25000000, hold cycles before the first auto-repeat.
REQ-004 Parameter REPEAT_PERIOD, default 10000000, cycles between auto-repeat pulses.
REQ-005 Parameter TIMEOUT_CYCLES, default 500000000, idle cycles in a SET state before returning to RUN.
REQ-006 Parameter BLINK_CYCLES, default 12500000, cycles per blink phase.
REQ-007 clk  in  1  system clock; all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 run_en  in  1  timekeeping enable; 0 freezes the prescaler.
REQ-010 btn_mode  in  1  raw, asynchronous mode button, active-high.
REQ-011 btn_up  in  1  raw, asynchronous increment button, active-high.
REQ-012 tick_1s  out  1  one-cycle seconds-advance strobe to the timekeeping datapath.
REQ-013 inc_hr, inc_min, inc_sec  out  1 each  one-cycle field-increment strobes.
REQ-014 mode  out  2  current state: 00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC.
REQ-015 blank_hr, blank_min, blank_sec  out  1 each  blank request for the blinking field.

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer, then a debouncer updating the debounced level only after DEBOUNCE_CYCLES consecutive equal synchronized samples differing from it.
REQ-017 A press SHALL be a 0->1 transition of the debounced level; the resulting strobe or state change occurs on the following cycle.
REQ-018 FSM on mode press: RUN->SET_HR->SET_MIN->SET_SEC->RUN; no other transitions except REQ-024.
REQ-019 Prescaler counts 0..CLK_HZ-1 only when mode=RUN and run_en=1; tick_1s=1 for exactly the cycle the count equals CLK_HZ-1, after which count wraps to 0.
REQ-020 run_en=0 in RUN SHALL hold the prescaler value and suppress tick_1s; counting resumes from the held value.
REQ-021 In any SET state the prescaler SHALL be held at 0 and tick_1s=0, so the first tick after returning to RUN occurs exactly CLK_HZ cycles after the exit.
REQ-022 Up press in SET_HR/SET_MIN/SET_SEC SHALL pulse inc_hr/inc_min/inc_sec respectively for one cycle; up presses in RUN are ignored.
REQ-023 Auto-repeat: while debounced up stays 1 in a SET state, extra pulses fire REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles; release or state change cancels repetition.
REQ-024 Idle counter resets on every press of either button; reaching TIMEOUT_CYCLES in a SET state SHALL force RUN.
REQ-025 Mode press and up press in the same cycle: mode wins, no inc pulse.
REQ-026 At most one of tick_1s, inc_hr, inc_min, inc_sec SHALL be high in any cycle.
REQ-027 Blink phase toggles every BLINK_CYCLES; blank of the selected field equals phase, others 0; all blanks 0 in RUN.
REQ-028 Blink counter and phase SHALL clear to 0 on every state change and every inc pulse, keeping the adjusted field visible.
REQ-029 All counters SHALL saturate or wrap only as stated; no count exceeds its parameter bound.

Reset
REQ-030 reset=1 SHALL immediately force mode=RUN, all strobes and blanks 0, synchronizers, debounced levels and all counters 0.
REQ-031 Reset asserted mid-SET or mid-repeat SHALL abort the sequence with no further strobes; after release a still-held button requires a fresh debounced press.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, TIMEOUT_CYCLES=100, BLINK_CYCLES=8)
REQ-032 Release reset, run_en=1, 35 cycles -> tick_1s pulses at cycles 10, 20, 30, each one cycle wide.
REQ-033 btn_mode glitch 2 cycles -> no mode change; btn_mode held 10 cycles -> mode=01, prescaler 0, blank_hr toggles every 8 cycles.
REQ-034 In SET_MIN hold btn_up 40 cycles -> inc_min at press+1, then +20, +25, +30, +35; no inc_hr/inc_sec/tick_1s.
REQ-035 Enter SET_SEC, no buttons 100 cycles -> mode=00; first tick_1s exactly 10 cycles later.
REQ-036 Mode and up debounced on the same cycle in SET_HR -> mode=10, no inc_hr.
REQ-037 Assert reset during auto-repeat -> strobes 0 immediately, mode=00; held btn_up after release yields no inc pulse.
